// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//   Instruction-fetch front end that sits directly upstream of the instruction
//   port of the unified memory. It owns the fetch PC, drives the memory's
//   instruction address, and captures the word the memory returns in the same
//   cycle into a small prefetch FIFO. Decode sees {PC, instruction} pairs
//   through a valid/ready handshake. A redirect flushes the queue and restarts
//   fetch at a new PC.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   RESET_PC  fetch PC after reset (bits [1:0] forced to 0)
//
// Ports
//   clk          in   1   clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   FetchEn      in   1   fetching allowed this cycle
//   Redirect     in   1   flush queue, restart fetch at RedirectPC
//   RedirectPC   in   32  new fetch PC (bits [1:0] ignored)
//   MemInstAddr  out  32  word-aligned fetch address (the FetchPC register)
//   MemReadInst  in   32  word returned by memory for MemInstAddr, same cycle
//   InstValid    out  1   head entry present
//   InstReady    in   1   decode accepts the head entry this cycle
//   Inst         out  32  head instruction word (0 when empty)
//   InstPC       out  32  head instruction byte address (0 when empty)
//
// Handshake: the head entry transfers to decode on a rising edge where
// InstValid and InstReady are both 1 and Redirect is 0. InstValid never depends
// on InstReady. A cycle with Redirect = 1 transfers nothing, even if
// InstValid and InstReady are both high; decode must treat it as not accepted.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FetchEn,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] MemInstAddr,
    input  logic [31:0] MemReadInst,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Inst,
    output logic [31:0] InstPC
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [CW-1:0] count;

    logic [31:0]   pc_store   [DEPTH];
    logic [31:0]   inst_store [DEPTH];

    logic          full;
    logic          pop;
    logic          push;

    assign full = (count == FULL_COUNT);

    // A full queue can still accept a new word when the head leaves in the
    // same cycle, which is what keeps streaming at one instruction per cycle.
    assign pop  = InstValid & InstReady & ~Redirect;
    assign push = FetchEn & ~Redirect & (~full | pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else if (Redirect) begin
            fetch_pc <= {RedirectPC[31:2], 2'b00};
            rptr     <= '0;
            wptr     <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                wptr     <= wptr + 1'b1;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: it is only read while count != 0, and every
    // entry is written before count can cover it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_store[wptr]   <= fetch_pc;
            inst_store[wptr] <= MemReadInst;
        end
    end

    assign MemInstAddr = fetch_pc;
    assign InstValid   = (count != '0);
    assign Inst        = InstValid ? inst_store[rptr] : 32'd0;
    assign InstPC      = InstValid ? pc_store[rptr]   : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_queue
//   Directed bench for inst_fetch_queue (DEPTH = 4, RESET_PC = 0). A small
//   memory model returns a word that is a fixed function of the address, so
//   expected instruction words are computed from the expected PC.
// -----------------------------------------------------------------------------
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] mem_inst_addr;
    logic [31:0] mem_read_inst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int n_vec;
    int n_err;

    inst_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .FetchEn     (fetch_en),
        .Redirect    (redirect),
        .RedirectPC  (redirect_pc),
        .MemInstAddr (mem_inst_addr),
        .MemReadInst (mem_read_inst),
        .InstValid   (inst_valid),
        .InstReady   (inst_ready),
        .Inst        (inst),
        .InstPC      (inst_pc)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory model ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h0F1E};
    endfunction

    assign mem_read_inst = mem_word(mem_inst_addr);

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic edge_step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
        check({tag, ".pc"},    inst_pc,             pc);
        check({tag, ".inst"},  inst,                mem_word(pc));
    endtask

    task automatic check_empty(input string tag);
        check({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
        check({tag, ".pc"},    inst_pc,             32'd0);
        check({tag, ".inst"},  inst,                32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst         = 1'b0;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        inst_ready  = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check_empty("reset");
        check("reset.addr", mem_inst_addr, 32'h0);
        edge_step();
        edge_step();
        rst = 1'b0;

        // Fill: one entry per edge, then hold while full
        fetch_en = 1'b1;
        edge_step();
        check_head("fill1", 32'h0);
        check("fill1.addr", mem_inst_addr, 32'h4);
        edge_step();
        check("fill2.addr", mem_inst_addr, 32'h8);
        edge_step();
        check("fill3.addr", mem_inst_addr, 32'hC);
        edge_step();
        check("fill4.addr", mem_inst_addr, 32'h10);
        for (int k = 0; k < 2; k++) begin
            edge_step();
            check("full_hold.addr", mem_inst_addr, 32'h10);
            check_head("full_hold", 32'h0);
        end

        // Streaming from full: one pop and one push per edge
        inst_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            edge_step();
            check_head("stream", 32'(4 * k));
            check("stream.addr", mem_inst_addr, 32'(32'h10 + 4 * k));
        end
        // Queue must still be full: fetch stalls once decode stops
        inst_ready = 1'b0;
        edge_step();
        check("still_full.addr", mem_inst_addr, 32'h28);
        edge_step();
        check("still_full2.addr", mem_inst_addr, 32'h28);
        check_head("still_full", 32'h18);

        // Redirect from a full queue with a live handshake
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        edge_step();
        check_empty("redir");
        check("redir.addr", mem_inst_addr, 32'h100);
        redirect   = 1'b0;
        inst_ready = 1'b0;
        edge_step();
        check_head("redir_fill", 32'h100);
        check("redir_fill.addr", mem_inst_addr, 32'h104);

        // FetchEn = 0: drain, then ready on empty queue must not underflow
        fetch_en   = 1'b0;
        inst_ready = 1'b1;
        edge_step();
        check_empty("drain");
        check("drain.addr", mem_inst_addr, 32'h104);
        edge_step();
        check_empty("empty_ready");
        fetch_en   = 1'b1;
        inst_ready = 1'b0;
        edge_step();
        check_head("refill", 32'h104);
        check("refill.addr", mem_inst_addr, 32'h108);

        // Address wrap at the top of memory
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        edge_step();
        check_empty("wrap_redir");
        check("wrap_redir.addr", mem_inst_addr, 32'hFFFF_FFF8);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        edge_step();
        check_head("wrap0", 32'hFFFF_FFF8);
        check("wrap0.addr", mem_inst_addr, 32'hFFFF_FFFC);
        edge_step();
        check_head("wrap1", 32'hFFFF_FFFC);
        check("wrap1.addr", mem_inst_addr, 32'h0);
        edge_step();
        check_head("wrap2", 32'h0);
        check("wrap2.addr", mem_inst_addr, 32'h4);

        // Asynchronous reset between edges
        edge_step();
        rst = 1'b1;
        #1;
        check_empty("async_rst");
        check("async_rst.addr", mem_inst_addr, 32'h0);
        #1 rst = 1'b0;
        inst_ready = 1'b0;
        edge_step();
        check_head("post_rst", 32'h0);
        check("post_rst.addr", mem_inst_addr, 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
